bp_io_cmd_arbiter: RTL and testbench
====================================

// Module: bp_io_cmd_arbiter
// PURPOSE
//  Shares one BedRock I/O command/response channel among num_req_p requesters
//  (NBF loader, host debug, config master). Round-robin grant, locked until the
//  downstream accept. Credit-limited outstanding count. Returns in-order
//  responses to the issuing requester using a tag FIFO of requester indices.
// PARAMETERS
//  num_req_p       3    number of requesters (>=2)
//  header_width_p  128  width of a flattened mem header
//  data_width_p    512  payload width (cce_block_width_p)
//  max_credits_p   16   maximum outstanding commands; also the tag FIFO depth
// PORTS
//  clk_i          in   1                       clock
//  reset_i        in   1                       async active-high reset
//  req_header_i   in   num_req_p*header_width_p per-requester cmd header
//  req_data_i     in   num_req_p*data_width_p   per-requester cmd data
//  req_v_i        in   num_req_p                per-requester cmd valid
//  req_yumi_o     out  num_req_p                one-hot accept back to requester
//  req_resp_v_o   out  num_req_p                one-hot response valid
//  req_resp_ready_i in num_req_p                per-requester response ready
//  io_cmd_header_o out header_width_p           muxed header
//  io_cmd_data_o  out  data_width_p             muxed data
//  io_cmd_v_o     out  1                        cmd valid
//  io_cmd_yumi_i  in   1                        downstream accept
//  io_resp_header_i in header_width_p           response header (broadcast to all)
//  io_resp_data_i in   data_width_p             response data (broadcast to all)
//  io_resp_v_i    in   1                        response valid
//  io_resp_ready_o out 1                        response ready
//  idle_o         out  1                        no outstanding cmds, nothing locked
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr pointer=0, credits=0, tag FIFO empty.
//    io_cmd_v_o=0, req_yumi_o=0, req_resp_v_o=0, io_resp_ready_o=0, idle_o=1.
//  - can_issue = (credits != max_credits_p) & ~tag_full.
//  - IDLE: winner = first set req_v_i, searching from rr pointer upward with wrap.
//    If any req_v_i and can_issue: io_cmd_v_o=1 and the winner's header/data
//    are driven. If io_cmd_yumi_i arrives the same cycle: req_yumi_o[winner]=1,
//    push the winner's index, credits+1, rr=(winner+1)%num_req_p, stay IDLE.
//    Otherwise latch the winner and go to LOCKED.
//  - LOCKED: drive the latched requester only; io_cmd_v_o=1 for as long as it
//    stays asserted. Other requests never preempt it. On io_cmd_yumi_i: same
//    updates as an accept in IDLE, then go to IDLE.
//    The requester must hold valid and payload until it sees yumi (assertion).
//  - Zero-cycle issue latency: io_cmd_v_o can rise in the cycle req_v_i rises.
//  - Response: head = tag FIFO head. io_resp_ready_o = ~empty &
//    req_resp_ready_i[head]. req_resp_v_o[head] = io_resp_v_i & ~empty.
//    A handshake pops the FIFO and does credits-1.
//  - Issue and response handshake in the same cycle: credits unchanged. Pop and
//    push in the same cycle are legal at full.
//  - io_resp_v_i while the FIFO is empty is illegal: ready stays 0 and an
//    assertion fires.
//  - Credit and pointer arithmetic are sized with `BSG_WIDTH/`BSG_SAFE_CLOG2.
//    rr wraps num_req_p-1 -> 0.
//  - idle_o = (credits==0) & (state==IDLE) & ~io_cmd_v_o.
//  - Reset mid-transaction drops all tags. Owners reset the downstream together.
// CONFIGURATION
//  BP_IO_ARB_PERF_EN defined: adds the output stall_cnt_o [32] and the output
//    grant_cnt_o [num_req_p*32]. stall_cnt_o counts cycles with any req_v_i
//    and ~can_issue. grant_cnt_o[i] counts accepts for requester i. Both are
//    saturating and async-reset to 0.
//  Macro undefined: these ports and counters do not exist. Function is unchanged.
// TESTING
//  1 num_req_p=3. req_v_i=3'b111 held, io_cmd_yumi_i=1 every cycle ->
//    grants 0,1,2,0,1,2. No cycle with two yumi bits set.
//  2 req_v_i=3'b010, yumi held low for 4 cycles, then req 0 also asserts ->
//    io_cmd_v_o stays on req 1 (LOCKED). After yumi the next grant is req 2 or 0,
//    following rr.
//  3 max_credits_p=4, no responses -> exactly 4 accepts, then io_cmd_v_o=0.
//    One response -> one more accept.
//  4 Issue order 2,0,1. Three responses -> req_resp_v_o = 100, 001, 010.
//    With req_resp_ready_i[2]=0 first: io_resp_ready_o=0 until it is raised.
//  5 credits=max_credits_p, then response and new request in the same cycle ->
//    accepted next cycle, credits back at max, FIFO still consistent.
//  6 Assert reset_i asynchronously in LOCKED with 3 outstanding ->
//    outputs go to reset values before the next clk_i edge. idle_o=1.

Source files
------------

// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock I/O cmd/resp channel among num_req_p requesters,
// with credit-limited issue and in-order response routing. Optional perf counters: BP_IO_ARB_PERF_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x) + 1))
`endif

module bp_io_cmd_arbiter #(
  parameter int num_req_p      = 3,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 512,
  parameter int max_credits_p  = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*header_width_p-1:0] req_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic [num_req_p-1:0]                req_resp_v_o,
  input  logic [num_req_p-1:0]                req_resp_ready_i,
  output logic [header_width_p-1:0]           io_cmd_header_o,
  output logic [data_width_p-1:0]             io_cmd_data_o,
  output logic                                io_cmd_v_o,
  input  logic                                io_cmd_yumi_i,
  input  logic [header_width_p-1:0]           io_resp_header_i,
  input  logic [data_width_p-1:0]             io_resp_data_i,
  input  logic                                io_resp_v_i,
  output logic                                io_resp_ready_o,
  output logic                                idle_o
`ifdef BP_IO_ARB_PERF_EN
  ,
  output logic [31:0]                         stall_cnt_o,
  output logic [num_req_p*32-1:0]             grant_cnt_o
`endif
);

  localparam int idx_w  = `BSG_SAFE_CLOG2(num_req_p);
  localparam int cred_w = `BSG_WIDTH(max_credits_p);
  localparam int ptr_w  = `BSG_SAFE_CLOG2(max_credits_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_r, state_n;
  logic [idx_w-1:0]   rr_r, rr_n, lock_r, lock_n, winner, sel, head;
  logic [cred_w-1:0]  credits_r, count_r;
  logic [ptr_w-1:0]   wr_ptr_r, rd_ptr_r;
  logic [idx_w-1:0]   tag_mem [max_credits_p];
  logic               found, can_issue, tag_full, tag_empty, accept, pop;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(max_credits_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign tag_full  = (count_r == cred_w'(max_credits_p));
  assign tag_empty = (count_r == '0);
  assign can_issue = (credits_r != cred_w'(max_credits_p)) & ~tag_full;

  // First valid requester at or above the rr pointer, wrapping around.
  always_comb begin
    winner = rr_r;
    found  = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!found && req_v_i[(int'(rr_r) + k) % num_req_p]) begin
        winner = idx_w'((int'(rr_r) + k) % num_req_p);
        found  = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state_r;
    rr_n       = rr_r;
    lock_n     = lock_r;
    req_yumi_o = '0;
    sel        = (state_r == LOCKED) ? lock_r : winner;
    // Outputs are forced to their reset values while reset is held.
    io_cmd_v_o = ~reset_i & ((state_r == LOCKED) ? req_v_i[lock_r] : (found & can_issue));
    accept     = io_cmd_v_o & io_cmd_yumi_i;
    if (accept) begin
      req_yumi_o[sel] = 1'b1;
      rr_n            = (sel == idx_w'(num_req_p - 1)) ? '0 : sel + idx_w'(1);
      state_n         = IDLE;
    end else if (io_cmd_v_o && state_r == IDLE) begin
      lock_n  = sel;
      state_n = LOCKED;
    end
  end

  assign io_cmd_header_o = req_header_i[int'(sel)*header_width_p +: header_width_p];
  assign io_cmd_data_o   = req_data_i[int'(sel)*data_width_p +: data_width_p];

  // Responses return in issue order; the FIFO head names the owner.
  always_comb begin
    head                 = tag_mem[rd_ptr_r];
    io_resp_ready_o      = ~tag_empty & req_resp_ready_i[head];
    req_resp_v_o         = '0;
    req_resp_v_o[head]   = io_resp_v_i & ~tag_empty;
    pop                  = io_resp_v_i & io_resp_ready_o;
  end

  assign idle_o = (credits_r == '0) & (state_r == IDLE) & ~io_cmd_v_o;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      rr_r      <= '0;
      lock_r    <= '0;
      credits_r <= '0;
      count_r   <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
    end else begin
      state_r <= state_n;
      rr_r    <= rr_n;
      lock_r  <= lock_n;
      if (accept) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop)    rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({accept, pop})
        2'b10: begin
          credits_r <= credits_r + cred_w'(1);
          count_r   <= count_r + cred_w'(1);
        end
        2'b01: begin
          credits_r <= credits_r - cred_w'(1);
          count_r   <= count_r - cred_w'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag storage is not reset; count_r alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (accept) tag_mem[wr_ptr_r] <= sel;
  end

`ifdef BP_IO_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stall_cnt_o <= '0;
    else if ((|req_v_i) && !can_issue && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end

  for (genvar i = 0; i < num_req_p; i++) begin : g_grant_cnt
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) grant_cnt_o[i*32 +: 32] <= '0;
      else if (req_yumi_o[i] && grant_cnt_o[i*32 +: 32] != '1)
        grant_cnt_o[i*32 +: 32] <= grant_cnt_o[i*32 +: 32] + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_hold_payload: assert property (@(posedge clk_i) disable iff (reset_i)
    (io_cmd_v_o && !io_cmd_yumi_i) |=> (io_cmd_v_o && $stable(io_cmd_header_o) && $stable(io_cmd_data_o)));
  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    io_resp_v_i |-> !tag_empty);
  a_resp_known: assert property (@(posedge clk_i) disable iff (reset_i)
    io_resp_v_i |-> !$isunknown({io_resp_header_i, io_resp_data_i}));
  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(req_yumi_o));
`endif

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Randomized scoreboard bench for bp_io_cmd_arbiter: a spec-level model predicts grants,
// credit stalls and response routing; two monitors compare against the DUT.
module tb_bp_io_cmd_arbiter;
  localparam int N = 3, HW = 16, DW = 32, MAX = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [N*HW-1:0]   req_header_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_v_i, req_yumi_o, req_resp_v_o, req_resp_ready_i;
  logic [HW-1:0]     io_cmd_header_o, io_resp_header_i;
  logic [DW-1:0]     io_cmd_data_o, io_resp_data_i;
  logic              io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o, idle_o;

  bp_io_cmd_arbiter #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW), .max_credits_p(MAX)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_header_i(req_header_i), .req_data_i(req_data_i), .req_v_i(req_v_i),
    .req_yumi_o(req_yumi_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
    .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o), .io_cmd_v_o(io_cmd_v_o),
    .io_cmd_yumi_i(io_cmd_yumi_i), .io_resp_header_i(io_resp_header_i), .io_resp_data_i(io_resp_data_i),
    .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Requester / downstream stimulus state
  logic [HW-1:0] hdr [N];
  logic [DW-1:0] dat [N];
  logic [N-1:0]  rv;
  logic          yumi, resp_v;
  logic [N-1:0]  rdy;
  bit            acc_seen, resp_hs;
  int            acc_idx;

  // Reference model: accepted minus answered commands, issue-order owner queue, rr pointer, lock
  int n_acc = 0, n_resp = 0;
  int exp_q[$], grant_log[$], resp_log[$];
  int rr_m = 0, lock_m = -1;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_header_i[i*HW +: HW] = hdr[i];
      req_data_i[i*DW +: DW]   = dat[i];
    end
    req_v_i          = rv;
    io_cmd_yumi_i    = yumi;
    io_resp_v_i      = resp_v;
    req_resp_ready_i = rdy;
  endtask

  task automatic drive(input int pv, input int py, input int pr, input int prdy, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (rv[i] && acc_seen && acc_idx == i) rv[i] = 1'b0;
      if (!rv[i] && mask[i] && int'($urandom_range(99)) < pv) begin
        rv[i]  = 1'b1;
        hdr[i] = HW'($urandom);
        dat[i] = $urandom;
      end
      rdy[i] = int'($urandom_range(99)) < prdy;
    end
    acc_seen = 0;
    if (resp_hs) begin
      resp_v  = 1'b0;
      resp_hs = 0;
    end
    if (!resp_v && (n_acc - n_resp) > 0 && int'($urandom_range(99)) < pr) begin
      resp_v           = 1'b1;
      io_resp_header_i = HW'($urandom);
      io_resp_data_i   = $urandom;
    end
    yumi = int'($urandom_range(99)) < py;
    apply();
  endtask

  task automatic run(input int n, input int pv, input int py, input int pr, input int prdy, input logic [N-1:0] mask);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      drive(pv, py, pr, prdy, mask);
    end
  endtask

  // Command-side monitor: grant choice, payload, credit stall, idle
  always @(negedge clk_i) begin : cmd_mon
    int out, w;
    bit exp_v;
    if (reset_i) begin
      rr_m   = 0;
      lock_m = -1;
      n_acc <= 0;
      exp_q.delete();
      acc_seen = 0;
    end else begin
      out = n_acc - n_resp;
      w   = -1;
      if (lock_m >= 0) begin
        w     = lock_m;
        exp_v = 1;
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && req_v_i[(rr_m + k) % N]) w = (rr_m + k) % N;
        exp_v = (w >= 0) && (out < MAX);
      end
      check("io_cmd_v", io_cmd_v_o, exp_v);
      if (exp_v) begin
        check("cmd_header", io_cmd_header_o, hdr[w]);
        check("cmd_data", io_cmd_data_o, dat[w]);
      end
      if (exp_v && io_cmd_yumi_i) begin
        check("req_yumi", req_yumi_o, 64'(1) << w);
        exp_q.push_back(w);
        grant_log.push_back(w);
        n_acc   <= n_acc + 1;
        rr_m     = (w + 1) % N;
        lock_m   = -1;
        acc_seen = 1;
        acc_idx  = w;
      end else begin
        check("req_yumi_quiet", req_yumi_o, 0);
        if (exp_v) lock_m = w;
      end
      check("idle", idle_o, (out == 0) && !exp_v);
    end
  end

  // Response-side monitor: routing to the oldest outstanding owner
  always @(negedge clk_i) begin : resp_mon
    int out, h;
    if (reset_i) begin
      n_resp <= 0;
      resp_hs = 0;
    end else begin
      out = n_acc - n_resp;
      if (out > 0) begin
        h = exp_q[0];
        check("resp_ready", io_resp_ready_o, req_resp_ready_i[h]);
        check("req_resp_v", req_resp_v_o, io_resp_v_i ? (64'(1) << h) : 64'(0));
        if (io_resp_v_i && req_resp_ready_i[h]) begin
          void'(exp_q.pop_front());
          resp_log.push_back(h);
          n_resp <= n_resp + 1;
          resp_hs = 1;
        end
      end else begin
        check("resp_quiet", {io_resp_ready_o, req_resp_v_o}, 0);
      end
    end
  end

  initial begin
    rv = '0; yumi = 0; resp_v = 0; rdy = '0;
    io_resp_header_i = '0; io_resp_data_i = '0;
    for (int i = 0; i < N; i++) begin hdr[i] = '0; dat[i] = '0; end
    apply();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_idle", idle_o, 1);
    check("rst_cmd_v", io_cmd_v_o, 0);
    check("rst_resp_ready", io_resp_ready_o, 0);
    reset_i = 1'b0;

    // All requesters valid, accept every cycle: strict rotation from 0
    run(8, 100, 100, 100, 100, 3'b111);
    for (int k = 0; k < 6; k++)
      check("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % 3);
    run(20, 0, 100, 100, 100, 3'b000);
    check("drained_idle", idle_o, 1);

    // Credit limit: no responses -> exactly MAX accepts; one response frees one slot
    grant_log.delete();
    run(10, 100, 100, 0, 100, 3'b111);
    check("credit_accepts", grant_log.size(), MAX);
    check("credit_stall_v", io_cmd_v_o, 0);
    run(1, 100, 100, 100, 100, 3'b111);
    run(5, 100, 100, 0, 100, 3'b111);
    check("credit_refill", grant_log.size(), MAX + 1);
    run(25, 0, 100, 100, 100, 3'b000);

    // Issue order 2,0,1; owner 2 not ready at first
    run(1, 100, 100, 0, 100, 3'b100);
    run(1, 100, 100, 0, 100, 3'b001);
    run(1, 100, 100, 0, 100, 3'b010);
    run(1, 0, 0, 0, 100, 3'b000);
    resp_log.delete();
    run(3, 0, 0, 100, 0, 3'b000);
    check("resp_blocked", resp_log.size(), 0);
    run(6, 0, 0, 100, 100, 3'b000);
    for (int k = 0; k < 3; k++)
      check("resp_order", (k < resp_log.size()) ? resp_log[k] : -1, (k == 0) ? 2 : k - 1);

    // Random traffic
    run(2000, 60, 50, 40, 70, 3'b111);
    run(30, 0, 100, 100, 100, 3'b000);
    check("random_drained_idle", idle_o, 1);

    // Async reset while LOCKED with 3 outstanding
    run(3, 100, 100, 0, 100, 3'b010);
    run(1, 100, 0, 0, 100, 3'b010);
    @(posedge clk_i);
    #2;
    check("locked_before_reset", io_cmd_v_o, 1);
    #1;
    reset_i = 1'b1;
    #1;
    check("arst_cmd_v", io_cmd_v_o, 0);
    check("arst_yumi", req_yumi_o, 0);
    check("arst_resp_v", req_resp_v_o, 0);
    check("arst_resp_ready", io_resp_ready_o, 0);
    check("arst_idle", idle_o, 1);
    rv = '0; yumi = 0; resp_v = 0; acc_seen = 0; resp_hs = 0;
    apply();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    run(300, 60, 50, 40, 70, 3'b111);
    run(30, 0, 100, 100, 100, 3'b000);
    check("final_idle", idle_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
